// File: rtl/median_window.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | median_window: windowed median/min/max using an odd-even transposition   |
// | sort over N buffered samples.   Revision: 1.0                            |
// +--------------------------------------------------------------------------+
module median_window #(
    parameter int W = 8,
    parameter int N = 9
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic [W-1:0] DI,
    input  logic         DSI,
    input  logic [1:0]   SEL,
    input  logic         CLR,
    output logic         RDY,
    output logic [W-1:0] DO,
    output logic         DSO,
    output logic         ERR
);

    localparam int c_cnt_w = $clog2(N + 1);
    localparam int c_ph_w  = $clog2(N);
    localparam int c_mid   = (N - 1) / 2;

    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(N - 1);
    localparam logic [c_ph_w-1:0]  c_ph_last  = c_ph_w'(N - 1);

    localparam logic [1:0] c_st_load = 2'd0;
    localparam logic [1:0] c_st_sort = 2'd1;
    localparam logic [1:0] c_st_out  = 2'd2;

    generate
        if ((N < 3) || ((N % 2) == 0)) begin : g_bad_n
            $error("median_window: N must be odd and at least 3");
        end
    endgenerate

    logic [1:0]         r_state;
    logic [1:0]         w_state_next;
    logic [c_cnt_w-1:0] r_cnt;
    logic [c_ph_w-1:0]  r_ph;
    logic [1:0]         r_ssel;
    logic [W-1:0]       r_mem  [N];
    logic [W-1:0]       w_next [N];
    logic [N-2:0]       w_swap;
    logic [W-1:0]       r_do;
    logic [W-1:0]       w_result;
    logic               r_dso;
    logic               r_err;
    logic               w_rdy;
    logic               w_take;
    logic               w_last;
    logic               w_ovr;

    assign w_take = (r_state == c_st_load) && DSI;
    assign w_last = w_take && (r_cnt == c_cnt_last);
    assign w_ovr  = DSI && (r_state != c_st_load);

    // Pairs whose lower index parity matches the phase parity are active; the
    // active pairs of one phase are disjoint, so all exchanges happen at once.
    generate
        for (genvar gi = 0; gi < N - 1; gi++) begin : g_pair
            localparam logic c_odd = 1'(gi % 2);
            assign w_swap[gi] = (r_ph[0] == c_odd) && (r_mem[gi] > r_mem[gi+1]);
        end

        for (genvar gk = 0; gk < N; gk++) begin : g_elem
            if (gk == 0) begin : g_first
                assign w_next[gk] = w_swap[gk] ? r_mem[gk+1] : r_mem[gk];
            end else if (gk == N - 1) begin : g_last
                assign w_next[gk] = w_swap[gk-1] ? r_mem[gk-1] : r_mem[gk];
            end else begin : g_mid
                assign w_next[gk] = w_swap[gk]   ? r_mem[gk+1] :
                                    w_swap[gk-1] ? r_mem[gk-1] : r_mem[gk];
            end
        end
    endgenerate

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= c_st_load;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_load: if (w_last) w_state_next = c_st_sort;
            c_st_sort: if (r_ph == c_ph_last) w_state_next = c_st_out;
            c_st_out:  w_state_next = c_st_load;
            default:   w_state_next = c_st_load;
        endcase
    end

    always_comb begin
        w_rdy = (r_state == c_st_load);
        case (r_ssel)
            2'd1:    w_result = r_mem[0];
            2'd2:    w_result = r_mem[N-1];
            default: w_result = r_mem[c_mid];
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_cnt  <= '0;
            r_ph   <= '0;
            r_ssel <= 2'd0;
            r_do   <= '0;
            r_dso  <= 1'b0;
            r_err  <= 1'b0;
            for (int k = 0; k < N; k++) begin
                r_mem[k] <= '0;
            end
        end else begin
            r_dso <= 1'b0;
            // An overrun in the same edge as CLR leaves the flag set.
            if (w_ovr) begin
                r_err <= 1'b1;
            end else if (CLR) begin
                r_err <= 1'b0;
            end
            case (r_state)
                c_st_load: begin
                    if (w_take) begin
                        r_mem[r_cnt] <= DI;
                        if (w_last) begin
                            r_cnt  <= '0;
                            r_ph   <= '0;
                            r_ssel <= SEL;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                c_st_sort: begin
                    for (int k = 0; k < N; k++) begin
                        r_mem[k] <= w_next[k];
                    end
                    r_ph <= r_ph + 1'b1;
                end
                c_st_out: begin
                    r_do  <= w_result;
                    r_dso <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign RDY = w_rdy;
    assign DO  = r_do;
    assign DSO = r_dso;
    assign ERR = r_err;

endmodule
`default_nettype wire

// File: tb/tb_median_window.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_median_window: scoreboard bench for median_window (N=9/W=8 and        |
// | N=3/W=12 instances).   Revision: 1.0                                     |
// +--------------------------------------------------------------------------+
module tb_median_window;

    localparam int c_n = 9;

    typedef struct {
        longint val;
        longint cyc;
    } exp_t;

    logic        CLK = 1'b0;
    logic        RST;
    logic [7:0]  DI;
    logic        DSI;
    logic [1:0]  SEL;
    logic        CLR;
    logic        RDY;
    logic [7:0]  DO;
    logic        DSO;
    logic        ERR;

    logic [11:0] DI2;
    logic        DSI2;
    logic [1:0]  SEL2;
    logic        CLR2;
    logic        RDY2;
    logic [11:0] DO2;
    logic        DSO2;
    logic        ERR2;

    exp_t   sb[$];
    exp_t   mon_e;
    longint cyc = 0;
    longint last_edge = 0;
    int     n_cmp = 0;
    int     n_bad = 0;

    median_window #(.W(8), .N(c_n)) u_dut (
        .CLK(CLK), .RST(RST), .DI(DI), .DSI(DSI), .SEL(SEL), .CLR(CLR),
        .RDY(RDY), .DO(DO), .DSO(DSO), .ERR(ERR)
    );

    median_window #(.W(12), .N(3)) u_dut3 (
        .CLK(CLK), .RST(RST), .DI(DI2), .DSI(DSI2), .SEL(SEL2), .CLR(CLR2),
        .RDY(RDY2), .DO(DO2), .DSO(DSO2), .ERR(ERR2)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Every DSO must correspond to a queued expectation: value and exact edge.
    always @(negedge CLK) begin
        if (DSO === 1'b1) begin
            chk("dso_expected", longint'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
                mon_e = sb.pop_front();
                chk("do_value", longint'(DO), mon_e.val);
                chk("dso_cycle", cyc, mon_e.cyc);
            end
        end
    end

    function automatic longint ref_out(input int unsigned v[c_n], input int sel);
        int unsigned s[c_n];
        int unsigned t;
        s = v;
        for (int i = 1; i < c_n; i++) begin
            for (int j = i; j > 0; j--) begin
                if (s[j-1] > s[j]) begin
                    t = s[j]; s[j] = s[j-1]; s[j-1] = t;
                end
            end
        end
        case (sel)
            1:       return longint'(s[0]);
            2:       return longint'(s[c_n-1]);
            default: return longint'(s[(c_n-1)/2]);
        endcase
    endfunction

    task automatic send(input int unsigned v, input int gap);
        repeat (gap) begin
            @(posedge CLK); #1;
        end
        DSI = 1'b1;
        DI  = 8'(v);
        @(posedge CLK); #1;
        DSI = 1'b0;
        DI  = 8'($urandom);
        last_edge = cyc;
    endtask

    task automatic finish_window(input bit toggle, input int ovr_at, input bit ovr_clr);
        int waited = 0;
        while (RDY !== 1'b1 && waited < 40) begin
            if (toggle) SEL = 2'($urandom);
            if (waited == ovr_at) begin
                DSI = 1'b1;
                DI  = 8'hAA;
                CLR = ovr_clr;
            end
            @(posedge CLK); #1;
            if (waited == ovr_at) begin
                DSI = 1'b0;
                CLR = 1'b0;
                chk("err_on_overrun", longint'(ERR), 1);
            end
            waited++;
        end
        chk("busy_edges", waited, c_n + 1);
    endtask

    task automatic run_window(input int unsigned v[c_n], input int sel, input int gmax,
                              input bit toggle, input int ovr_at, input bit ovr_clr);
        exp_t e;
        SEL = 2'(sel);
        for (int i = 0; i < c_n; i++) begin
            send(v[i], (gmax > 0 && i > 0) ? int'($urandom_range(gmax, 1)) : 0);
        end
        e.val = ref_out(v, sel);
        e.cyc = last_edge + c_n + 1;
        sb.push_back(e);
        finish_window(toggle, ovr_at, ovr_clr);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned wa[c_n];
        int unsigned wv[c_n];
        longint e2;
        int waited;

        RST = 1'b1; DSI = 1'b0; DI = '0; SEL = 2'd0; CLR = 1'b0;
        DSI2 = 1'b0; DI2 = '0; SEL2 = 2'd0; CLR2 = 1'b0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("rst_do", longint'(DO), 0);
        chk("rst_dso", longint'(DSO), 0);
        chk("rst_rdy", longint'(RDY), 1);
        chk("rst_err", longint'(ERR), 0);
        @(posedge CLK); #1;
        RST = 1'b0;
        @(posedge CLK); #1;
        chk("post_rst_rdy", longint'(RDY), 1);
        chk("post_rst_do", longint'(DO), 0);

        wa = '{5, 3, 8, 1, 9, 2, 7, 4, 6};
        run_window(wa, 0, 0, 1'b0, -1, 1'b0);
        run_window(wa, 1, 0, 1'b0, -1, 1'b0);
        run_window(wa, 2, 0, 1'b0, -1, 1'b0);
        run_window(wa, 3, 0, 1'b0, -1, 1'b0);
        run_window(wa, 0, 0, 1'b1, -1, 1'b0);

        wv = '{9, 8, 7, 6, 5, 4, 3, 2, 1};
        run_window(wv, 0, 0, 1'b0, -1, 1'b0);
        wv = '{255, 255, 255, 255, 255, 255, 255, 255, 255};
        run_window(wv, 0, 0, 1'b0, -1, 1'b0);
        wv = '{0, 255, 0, 255, 0, 255, 0, 255, 0};
        run_window(wv, 0, 0, 1'b0, -1, 1'b0);

        // Overrun during SORT, hold, clear, then clear colliding with overrun.
        run_window(wa, 0, 0, 1'b0, 2, 1'b0);
        repeat (3) begin @(posedge CLK); #1; end
        chk("err_held", longint'(ERR), 1);
        CLR = 1'b1;
        @(posedge CLK); #1;
        CLR = 1'b0;
        chk("err_cleared", longint'(ERR), 0);
        run_window(wa, 2, 0, 1'b0, 5, 1'b1);
        chk("err_set_wins", longint'(ERR), 1);

        // Reset in the middle of LOAD.
        for (int i = 0; i < 4; i++) send(wa[i], 0);
        RST = 1'b1;
        #2;
        chk("midload_rst_do", longint'(DO), 0);
        chk("midload_rst_err", longint'(ERR), 0);
        chk("midload_rst_rdy", longint'(RDY), 1);
        @(posedge CLK); #1;
        RST = 1'b0;
        #1;
        chk("midload_rel_dso", longint'(DSO), 0);
        wv = '{10, 20, 30, 40, 50, 60, 70, 80, 90};
        run_window(wv, 0, 0, 1'b0, -1, 1'b0);

        // Reset in the middle of SORT: no DSO may follow.
        SEL = 2'd0;
        for (int i = 0; i < c_n; i++) send(wa[i], 0);
        repeat (3) begin @(posedge CLK); #1; end
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
        repeat (c_n + 4) begin @(posedge CLK); #1; end
        chk("midsort_rst_rdy", longint'(RDY), 1);

        for (int k = 0; k < 5; k++) begin
            for (int i = 0; i < c_n; i++) wv[i] = $urandom_range(255, 0);
            run_window(wv, int'($urandom_range(3, 0)), 3, 1'b0, -1, 1'b0);
        end

        for (int k = 0; k < 30; k++) begin
            for (int i = 0; i < c_n; i++) begin
                wv[i] = ($urandom_range(1, 0) == 1) ? $urandom_range(3, 0) : $urandom_range(255, 0);
            end
            run_window(wv, int'($urandom_range(3, 0)), int'($urandom_range(3, 0)),
                       1'($urandom_range(1, 0)), -1, 1'b0);
        end

        // N=3, W=12 instance.
        DSI2 = 1'b1; DI2 = 12'h800;
        @(posedge CLK); #1;
        DI2 = 12'h001;
        @(posedge CLK); #1;
        DI2 = 12'hFFF;
        @(posedge CLK); #1;
        DSI2 = 1'b0;
        e2 = cyc;
        waited = 0;
        while (DSO2 !== 1'b1 && waited < 20) begin
            @(negedge CLK);
            waited++;
        end
        chk("n3_dso_seen", longint'(DSO2), 1);
        chk("n3_do", longint'(DO2), 64'h800);
        chk("n3_latency", cyc, e2 + 4);

        repeat (12) @(posedge CLK);
        chk("sb_drained", longint'(sb.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
